bnn_conv_seq: RTL

Parametrised, time-multiplexed binary convolution layer for the BNN classifier datapath. It accepts one flattened binary feature map of C_IN channels, and for every output position computes, for all C_OUT channels in parallel, the XNOR-match count over a K×K×C_IN window. Each count is compared against a per-channel offset, and the binary output map is returned through a valid/ready handshake. It supersedes the fully-parallel conv + accumulate/binarise stages, trading latency (one output position per cycle) for area, and adds an optional fused 2×2 pool.

---
 rtl/bnn_pkg.sv | 33 +++
 rtl/bnn_xnor_popcount.sv | 35 +++
 rtl/bnn_conv_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// bnn_pkg: shared types and helpers for the BNN classifier datapath.
//   bnn_state_e  - layer sequencer states (IDLE, COMPUTE, DONE)
//   idx_w(n)     - bits needed to index n items (minimum 1)
//   cnt_w(n)     - bits needed to hold a count 0..n (minimum 1)
//   fmap_idx()   - flat bit index of (channel, y, x) in an h x w map
//   kern_idx()   - flat bit index of (channel, ky, kx) in a k x k kernel
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } bnn_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  function automatic int fmap_idx(input int c, input int y, input int x,
                                  input int h, input int w);
    return (c * h + y) * w + x;
  endfunction

  function automatic int kern_idx(input int c, input int ky, input int kx,
                                  input int k);
    return (c * k + ky) * k + kx;
  endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// bnn_xnor_popcount: one output channel of a binary convolution tap.
// Counts positions where window and kernel agree (XNOR popcount) and
// binarises the count against a zero-extended offset. Purely combinational.
//   win    [N]     - window bits
//   kern   [N]     - kernel bits, same ordering as win
//   offset [OFF_W] - threshold; 0 always fires, > N never fires
//   bit_o          - (match >= offset)
module bnn_xnor_popcount
  import bnn_pkg::*;
#(
  parameter int N     = 25,
  parameter int OFF_W = 8
) (
  input  logic [N-1:0]     win,
  input  logic [N-1:0]     kern,
  input  logic [OFF_W-1:0] offset,
  output logic             bit_o
);

  localparam int MW = cnt_w(N);

  logic [N-1:0]  xn;
  logic [MW-1:0] match;

  assign xn = ~(win ^ kern);

  always_comb begin
    match = '0;
    for (int i = 0; i < N; i++) match = match + MW'(xn[i]);
  end

  // Both sides widened to MW+OFF_W so neither operand can be truncated.
  assign bit_o = ({{OFF_W{1'b0}}, match} >= {{MW{1'b0}}, offset});

endmodule

// File: rtl/bnn_conv_seq.sv
// bnn_conv_seq: time-multiplexed binary convolution layer.
// One output position (all C_OUT channels in parallel) per COMPUTE cycle.
// Optional fused 2x2 OR-pool when BNN_CONV_POOL_EN is defined.
//   clk, rst_n       - clock, synchronous active-low reset
//   w_valid/w_ready  - kernel/offset write (accepted in IDLE only)
//   w_addr/w_data/w_offset - channel, kernel bits (ci*K+ky)*K+kx, threshold
//   in_valid/in_ready/in_fmap - input map, bit (ci*IMG_H+y)*IMG_W+x
//   out_valid/out_ready/out_fmap - result, bit (co*OUT_H+y)*OUT_W+x
module bnn_conv_seq
  import bnn_pkg::*;
#(
  parameter int IMG_H = 28,
  parameter int IMG_W = 28,
  parameter int K     = 5,
  parameter int C_IN  = 1,
  parameter int C_OUT = 18,
  parameter int OFF_W = 8,
  localparam int OH   = IMG_H - K + 1,
  localparam int OW   = IMG_W - K + 1,
`ifdef BNN_CONV_POOL_EN
  localparam int OUT_H = OH / 2,
  localparam int OUT_W = OW / 2,
`else
  localparam int OUT_H = OH,
  localparam int OUT_W = OW,
`endif
  localparam int AW   = idx_w(C_OUT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [AW-1:0]                w_addr,
  input  logic [C_IN*K*K-1:0]          w_data,
  input  logic [OFF_W-1:0]             w_offset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [C_IN*IMG_H*IMG_W-1:0]  in_fmap,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [C_OUT*OUT_H*OUT_W-1:0] out_fmap
);

  localparam int WN   = C_IN * K * K;
  localparam int FN   = C_IN * IMG_H * IMG_W;
  localparam int RN   = C_OUT * OUT_H * OUT_W;
  localparam int FI_W = idx_w(FN);
  localparam int RI_W = idx_w(RN);
  localparam int RW   = idx_w(OH);
  localparam int CW   = idx_w(OW);

`ifdef BNN_CONV_POOL_EN
  if ((OH % 2) != 0 || (OW % 2) != 0) begin : g_pool_chk
    $error("bnn_conv_seq: pooling needs even conv output dims");
  end
`endif

  bnn_state_e                  state_q;
  logic [RW-1:0]               row_q;
  logic [CW-1:0]               col_q;
  logic [FN-1:0]               fmap_q;
  logic [C_OUT-1:0][WN-1:0]    kern_q;
  logic [C_OUT-1:0][OFF_W-1:0] off_q;
  logic [RN-1:0]               res_q;
  logic [WN-1:0]               win;
  logic [C_OUT-1:0]            conv_bit;

  // Handshake flags come straight off the state register.
  assign in_ready  = (state_q == IDLE);
  assign w_ready   = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_fmap  = res_q;

  // Gather the K x K x C_IN window anchored at (row_q, col_q).
  always_comb begin : win_gather
    win = '0;
    for (int ci = 0; ci < C_IN; ci++)
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++)
          win[kern_idx(ci, ky, kx, K)] =
            fmap_q[FI_W'(fmap_idx(ci, int'(row_q) + ky, int'(col_q) + kx,
                                  IMG_H, IMG_W))];
  end

  for (genvar co = 0; co < C_OUT; co++) begin : g_ch
    bnn_xnor_popcount #(
      .N     (WN),
      .OFF_W (OFF_W)
    ) u_xp (
      .win    (win),
      .kern   (kern_q[co]),
      .offset (off_q[co]),
      .bit_o  (conv_bit[co])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      fmap_q  <= '0;
      res_q   <= '0;
      kern_q  <= '0;
      off_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A write landing with the accept is visible from the first
          // COMPUTE cycle, so that map already uses it.
          if (w_valid && (int'(w_addr) < C_OUT)) begin
            kern_q[w_addr] <= w_data;
            off_q[w_addr]  <= w_offset;
          end
          if (in_valid) begin
            fmap_q  <= in_fmap;
            row_q   <= '0;
            col_q   <= '0;
            res_q   <= '0;
            state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          for (int co = 0; co < C_OUT; co++) begin
`ifdef BNN_CONV_POOL_EN
            // Four conv positions fold into each pooled bit; the register
            // was cleared on accept so OR-accumulation is exact.
            res_q[RI_W'(fmap_idx(co, int'(row_q >> 1), int'(col_q >> 1),
                                 OUT_H, OUT_W))] <=
              res_q[RI_W'(fmap_idx(co, int'(row_q >> 1), int'(col_q >> 1),
                                   OUT_H, OUT_W))] | conv_bit[co];
`else
            res_q[RI_W'(fmap_idx(co, int'(row_q), int'(col_q), OH, OW))] <=
              conv_bit[co];
`endif
          end
          if (col_q == CW'(OW - 1)) begin
            col_q <= '0;
            if (row_q == RW'(OH - 1)) state_q <= DONE;
            else                      row_q   <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
